// File: rtl/booth_product_divider.sv
// Sequential signed restoring divider (truncating), one quotient bit per clock.
// Optional dividend reconstruction check enabled by defining BOOTH_DIV_SELFCHECK_EN.
module booth_product_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow,
  output logic          check_err
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [VW-1:0]   pr_reg;
  logic [DW-1:0]   q_reg;
  logic [VW:0]     dmag_reg;
  logic [VW-1:0]   dvd_low_reg;
  logic            neg_dvd_reg, neg_dvs_reg, zero_dvs_reg;

  logic            accept;
  logic [VW:0]     dvs_ext, dvs_abs;
  logic [DW-1:0]   dvd_abs;
  logic [VW:0]     shifted;
  logic            ge;
  logic [VW-1:0]   sub, pr_step;
  logic [DW-1:0]   q_fix;
  logic [VW-1:0]   r_fix;
  logic            dbz_fix, ovf_fix;

  assign busy   = (state_reg == RUN) || (state_reg == FIX);
  assign done   = (state_reg == DONE);
  assign accept = start && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count_reg == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Magnitudes: |divisor| needs VW+1 bits so the most-negative divisor works.
  assign dvs_ext = {divisor[VW-1], divisor};
  assign dvs_abs = divisor[VW-1] ? (~dvs_ext + (VW+1)'(1)) : dvs_ext;
  assign dvd_abs = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;

  // Restoring step: partial remainder stays below |divisor|, so VW bits hold it.
  assign shifted = {pr_reg, q_reg[DW-1]};
  assign ge      = (shifted >= dmag_reg);
  assign sub     = shifted[VW-1:0] - dmag_reg[VW-1:0];
  assign pr_step = ge ? sub : shifted[VW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      pr_reg       <= '0;
      q_reg        <= '0;
      dmag_reg     <= '0;
      dvd_low_reg  <= '0;
      neg_dvd_reg  <= 1'b0;
      neg_dvs_reg  <= 1'b0;
      zero_dvs_reg <= 1'b0;
    end else if (accept) begin
      count_reg    <= CW'(DW-1);
      pr_reg       <= '0;
      q_reg        <= dvd_abs;
      dmag_reg     <= dvs_abs;
      dvd_low_reg  <= dividend[VW-1:0];
      neg_dvd_reg  <= dividend[DW-1];
      neg_dvs_reg  <= divisor[VW-1];
      zero_dvs_reg <= (divisor == '0);
    end else if (state_reg == RUN) begin
      pr_reg <= pr_step;
      q_reg  <= {q_reg[DW-2:0], ge};
      if (count_reg != '0) count_reg <= count_reg - CW'(1);
    end
  end

  always_comb begin
    dbz_fix = zero_dvs_reg;
    // Only a positive quotient of magnitude 2^(DW-1) is unrepresentable.
    ovf_fix = !zero_dvs_reg && !(neg_dvd_reg ^ neg_dvs_reg) && q_reg[DW-1];
    q_fix   = (neg_dvd_reg ^ neg_dvs_reg) ? (~q_reg + DW'(1)) : q_reg;
    r_fix   = neg_dvd_reg ? (~pr_reg + VW'(1)) : pr_reg;
    if (zero_dvs_reg) begin
      q_fix = '1;
      r_fix = dvd_low_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (state_reg == FIX) begin
      quotient    <= q_fix;
      remainder   <= r_fix;
      div_by_zero <= dbz_fix;
      overflow    <= ovf_fix;
    end
  end

`ifdef BOOTH_DIV_SELFCHECK_EN
  logic [DW-1:0]    dvd_cap_reg;
  logic [VW-1:0]    dvs_cap_reg;
  logic [DW+VW-1:0] recon;
  logic             chk_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_cap_reg <= '0;
      dvs_cap_reg <= '0;
    end else if (accept) begin
      dvd_cap_reg <= dividend;
      dvs_cap_reg <= divisor;
    end
  end

  // Low DW+VW bits of the product are sign-agnostic once both operands are extended.
  always_comb begin
    recon = ({{VW{q_fix[DW-1]}}, q_fix} * {{DW{dvs_cap_reg[VW-1]}}, dvs_cap_reg})
          + {{DW{r_fix[VW-1]}}, r_fix};
    chk_fail = !dbz_fix && !ovf_fix && (recon != {{VW{dvd_cap_reg[DW-1]}}, dvd_cap_reg});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 check_err <= 1'b0;
    else if (state_reg == FIX)  check_err <= chk_fail;
  end
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_product_divider.sv
// Directed and sweep bench for booth_product_divider (DW=8, VW=4).
module tb_booth_product_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero, overflow, check_err;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  booth_product_divider #(.DW(8), .VW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow), .check_err(check_err)
  );

  always #5 clk = ~clk;

  // Accept one operation and return the edge count until done (accept edge = 1).
  task automatic do_op(input int a, input int b, output int lat);
    @(negedge clk);
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow, check_err} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b chk=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero, overflow, check_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int va[6] = '{-56, 100, -100, -128,  5, 5};
    int vb[6] = '{  7,  -7,    7,   -1, -8, 0};
    int eq[6] = '{ -8, -14,  -14, -128,  0, -1};
    int er[6] = '{  0,   2,   -2,    0,  5, 5};
    logic [1:0] ef[6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], lat);
      $display("op %0d / %0d -> q=%0d r=%0d dbz=%b ovf=%b latency=%0d",
               va[i], vb[i], $signed(quotient), $signed(remainder), div_by_zero, overflow, lat);
      n_checks++;
      if (lat != 10) begin
        n_fail++;
        $display("FAIL latency_%0d: got %0d edges, required 10", i, lat);
      end
      n_checks++;
      if (quotient !== 8'(eq[i])) begin
        n_fail++;
        $display("FAIL quotient_%0d: got %0d, required %0d", i, $signed(quotient), eq[i]);
      end
      n_checks++;
      if (remainder !== 4'(er[i])) begin
        n_fail++;
        $display("FAIL remainder_%0d: got %0d, required %0d", i, $signed(remainder), er[i]);
      end
      n_checks++;
      if ({div_by_zero, overflow} !== ef[i]) begin
        n_fail++;
        $display("FAIL flags_%0d: got dbz/ovf=%b%b, required %b", i, div_by_zero, overflow, ef[i]);
      end
      n_checks++;
      if (busy !== 1'b0 || check_err !== 1'b0) begin
        n_fail++;
        $display("FAIL done_state_%0d: got busy=%b chk=%b, required 0 0", i, busy, check_err);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || quotient !== 8'hF8) begin
          n_fail++;
          $display("FAIL hold_after_done: got done=%b q=%h, required done=0 q=f8", done, quotient);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int va[4] = '{100, -56, 100, -56};
    int vb[4] = '{ -7,   7,  -7,   7};
    int eq[4] = '{-14,  -8, -14,  -8};
    int er[4] = '{  2,   0,   2,   0};
    int cnt;
    @(negedge clk);
    dividend = 8'(va[0]); divisor = 4'(vb[0]); start = 1'b1;
    @(posedge clk); #1;
    dividend = 8'(va[1]); divisor = 4'(vb[1]);
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      while (done !== 1'b1 && cnt < 30) begin
        @(posedge clk); #1;
        cnt++;
      end
      $display("b2b op %0d / %0d -> q=%0d r=%0d gap=%0d", va[i], vb[i],
               $signed(quotient), $signed(remainder), cnt);
      n_checks++;
      if (cnt != 9 || quotient !== 8'(eq[i]) || remainder !== 4'(er[i])) begin
        n_fail++;
        $display("FAIL b2b_%0d: got gap=%0d q=%0d r=%0d, required gap=9 q=%0d r=%0d",
                 i, cnt, $signed(quotient), $signed(remainder), eq[i], er[i]);
      end
      if (i == 3) start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== (i != 3)) begin
        n_fail++;
        $display("FAIL b2b_accept_%0d: got busy=%b, required %b", i, busy, i != 3);
      end
      if (i < 2) begin
        dividend = 8'(va[i+2]); divisor = 4'(vb[i+2]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int seen;
    @(negedge clk);
    dividend = 8'd100; divisor = 4'(-7); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    dividend = 8'(-56); divisor = 4'd7;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 4) start = 1'b1;
      if (lat == 5) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    $display("mid-run start op 100 / -7 -> q=%0d r=%0d latency=%0d", $signed(quotient), $signed(remainder), lat);
    n_checks++;
    if (lat != 10 || quotient !== 8'(-14) || remainder !== 4'd2) begin
      n_fail++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d, required lat=10 q=-14 r=2",
               lat, $signed(quotient), $signed(remainder));
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL start_not_queued: got %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    int lat;
    @(negedge clk);
    dividend = 8'(-100); divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-run: busy=%b done=%b q=%h r=%h", busy, done, quotient, remainder);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow, check_err} !== 17'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b chk=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero, overflow, check_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles, required 0", seen);
    end
    do_op(-100, 7, lat);
    $display("op -100 / 7 after abort -> q=%0d r=%0d latency=%0d", $signed(quotient), $signed(remainder), lat);
    n_checks++;
    if (lat != 10 || quotient !== 8'(-14) || remainder !== 4'(-2)) begin
      n_fail++;
      $display("FAIL abort_recover: got lat=%0d q=%0d r=%0d, required lat=10 q=-14 r=-2",
               lat, $signed(quotient), $signed(remainder));
    end
  endtask

  task automatic test_sweep();
    int lat, eq, er, bad;
    logic dz, ov;
    bad = 0;
    for (int a = -128; a < 128; a++) begin
      for (int b = -8; b < 8; b++) begin
        dz = 1'b0; ov = 1'b0;
        if (b == 0) begin
          eq = -1; er = a; dz = 1'b1;
        end else if (a == -128 && b == -1) begin
          eq = -128; er = 0; ov = 1'b1;
        end else begin
          eq = a / b; er = a % b;
        end
        do_op(a, b, lat);
        n_checks++;
        if (lat != 10 || quotient !== 8'(eq) || remainder !== 4'(er) ||
            div_by_zero !== dz || overflow !== ov || check_err !== 1'b0) begin
          n_fail++;
          bad++;
          if (bad <= 10)
            $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b ovf=%b chk=%b, required lat=10 q=%0d r=%0d dbz=%b ovf=%b chk=0",
                     a, b, lat, $signed(quotient), $signed(remainder), div_by_zero, overflow, check_err,
                     eq, 4'(er) > 7 ? 4'(er) - 16 : 4'(er), dz, ov);
        end
      end
    end
    $display("sweep of 4096 operand pairs complete, %0d mismatching", bad);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_product_divider.md
Name: booth_product_divider

Overview:
- Sequential signed divider that reverses the Booth multiply path: it takes a signed product-width dividend and a signed multiplier-width divisor, and returns quotient and remainder.
- Used to recover one multiplier operand from a product, e.g. op1 / in3 recovers in1+in2.
- Shift-subtract datapath, one quotient bit per clock, start/done handshake.
- Truncating semantics (quotient rounds toward zero), matching Verilog signed `/` and `%`.

Parameters:
- DW, 8, dividend and quotient width in bits (two's complement).
- VW, 4, divisor and remainder width in bits (two's complement); VW < DW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DW  signed dividend; captured on the accepting edge.
- divisor  input  VW  signed divisor; captured on the accepting edge.
- busy  output  1  high while a division is in flight.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  DW  signed quotient.
- remainder  output  VW  signed remainder, same sign as dividend or zero.
- div_by_zero  output  1  divisor was 0 for the result being presented.
- overflow  output  1  true quotient is not representable in DW bits.
- check_err  output  1  self-check mismatch (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, quotient, remainder, div_by_zero, overflow, check_err all 0. Reset during RUN/FIX aborts the division; no done is issued after release.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start=1: capture operands, latch sign flags, take absolute values into a (DW+VW)-bit magnitude workspace, load counter=DW-1, go to RUN, busy=1.
- RUN: each edge shifts the partial remainder left by 1 and trial-subtracts |divisor|.
  - If the result is non-negative: keep it, quotient bit=1.
  - Otherwise: restore, quotient bit=0.
  - When counter=0: go to FIX; otherwise decrement.
  - Exactly DW edges in RUN.
- FIX: apply signs.
  - quotient negated if the dividend and divisor signs differ.
  - remainder negated if dividend < 0.
  - Flags computed here.
  - Next edge: DONE.
- DONE: done=1 and busy=0 for exactly one cycle. Next state IDLE, or RUN if start=1 (back-to-back accepted).
- Latency: done is high in the cycle following the (DW+2)th rising edge after the accepting edge, counting the accepting edge as edge 1. For defaults, the pulse follows edge 10. Latency is identical for all operand values, including divide-by-zero.
- start while busy=1 is ignored and not queued. Operand inputs may change freely after acceptance.
- Result outputs and flags update only on the edge into DONE and hold until the next DONE.
- Divisor = 0: div_by_zero=1, quotient = all ones (-1), remainder = dividend[VW-1:0], overflow=0.
- Dividend = -2^(DW-1) and divisor = -1: overflow=1, quotient = -2^(DW-1) (wrapped), remainder=0.
- The most-negative divisor (-2^(VW-1)) must be handled correctly, so |divisor| is held in VW+1 bits.
- Remainder magnitude is always < |divisor|, so it fits in VW signed bits.

Optional Feature:
- Macro: BOOTH_DIV_SELFCHECK_EN.
- Defined: in the FIX state, compute quotient*divisor + remainder at DW+VW width, sign-extended. Compare it with the captured dividend, skipping the comparison when div_by_zero or overflow is set. check_err is registered into DONE alongside the results and held with them; it is 1 on mismatch.
- Not defined: no multiplier logic is built; check_err is tied to 0.

Test Plan:
- dividend=-56, divisor=7 -> quotient=-8, remainder=0, flags 0, done exactly 10 edges after accept.
- dividend=100, divisor=-7 -> quotient=-14, remainder=2. Then dividend=-100, divisor=7 -> quotient=-14, remainder=-2.
- dividend=-128, divisor=-1 -> overflow=1, quotient=-128, remainder=0. Then dividend=5, divisor=-8 -> quotient=0, remainder=5.
- dividend=5, divisor=0 -> div_by_zero=1, quotient=-1, remainder=5, latency still 10.
- start held high continuously with alternating operands -> a new accept in each DONE cycle, done every 10 cycles. A start pulse mid-RUN is ignored, and the results of the in-flight operation are unchanged.
- Reset asserted at RUN edge 4 -> all outputs 0 immediately; after release, no done until a new start. Exhaustive sweep with BOOTH_DIV_SELFCHECK_EN defined -> check_err never 1.
